fetch_seq_ctrl: RTL and testbench
=================================

// Module: fetch_seq_ctrl
// PURPOSE
// Sequences instruction fetch for the single-issue core. Owns the PC register,
// drives a request/response handshake to instruction memory and presents one
// instruction at a time to decode over valid/ready. Next PC is PC+4, or PC+br_offset
// on a taken branch. Sits between the PC/IM datapath and the decode stage.
// PARAMETERS
// XLEN         64        PC / offset width
// RESET_PC     64'd0     PC loaded on reset
// TIMEOUT_CYC  16        WAIT cycles before fetch error (FETCH_TIMEOUT_EN only)
// PORTS
// clk          in   1     clock, rising edge
// rst          in   1     synchronous, active-low reset
// start        in   1     begin/resume fetching (IDLE only)
// halt         in   1     stop after current instruction handshakes
// br_taken     in   1     redirect, sampled on decode handshake only
// br_offset    in   XLEN  PC-relative branch offset, two's complement
// imem_req     out  1     one-cycle fetch request
// imem_addr    out  XLEN  fetch address, valid while imem_req=1
// imem_rvalid  in   1     read data valid, >=1 cycle after imem_req
// imem_rdata   in   32    instruction word
// inst_valid   out  1     instruction available to decode
// inst_ready   in   1     decode accepts instruction
// inst         out  32    instruction word
// inst_pc      out  XLEN  PC of inst
// busy         out  1     state != IDLE
// fetch_err    out  1     sticky fetch timeout; constant 0 without macro
// BEHAVIOUR
// - Reset (rst=0 at clk edge): pc=RESET_PC, state=IDLE, all outputs 0. Overrides
//   every state. Late imem_rvalid after reset is ignored.
// - States: IDLE, REQ, WAIT, HOLD. All outputs registered.
// - IDLE: start=1 & halt=0 & fetch_err=0 -> REQ. Otherwise stay. rvalid ignored.
// - REQ: imem_req=1, imem_addr=pc for exactly one cycle -> WAIT. rvalid ignored.
// - WAIT: on imem_rvalid: inst<=imem_rdata, inst_pc<=pc -> HOLD (inst_valid=1
//   next cycle). Otherwise stay.
// - HOLD: inst_valid=1. inst and inst_pc stable until inst_ready=1.
//   On handshake: pc <= br_taken ? inst_pc+br_offset : inst_pc+4, computed
//   modulo 2^XLEN (wraps, no carry out). Next state = halt ? IDLE : REQ.
//   inst_valid drops the cycle after handshake.
// - br_taken/br_offset outside the HOLD handshake cycle: ignored.
// - halt during REQ/WAIT: fetch completes. Instruction is presented; IDLE after its handshake.
// - Resume from IDLE continues at the retained pc. Only reset restores RESET_PC.
// - start outside IDLE: ignored.
// - Throughput with 1-cycle memory and inst_ready=1: one instruction per 3 cycles.
// - No alignment check. imem_addr = pc as computed.
// CONFIGURATION
// - FETCH_TIMEOUT_EN defined:
//   - Counter clears on REQ and increments each WAIT cycle.
//   - At TIMEOUT_CYC cycles without rvalid: fetch_err<=1 (sticky until reset), state->IDLE.
//   - While fetch_err=1, start is ignored.
// - FETCH_TIMEOUT_EN undefined: no counter. WAIT waits indefinitely. fetch_err tied 0.
// TESTING
// - Reset, start=1, 1-cycle mem returning 32'h00000013, ready=1:
//   imem_addr 0,4,8 on successive requests. inst_pc 0,4,8. inst=32'h00000013.
// - Branch: hold inst_pc=8 with ready=1, br_taken=1, br_offset=-8:
//   next imem_addr=0. br_taken=1 outside handshake: no effect.
// - Backpressure: ready=0 for 5 cycles in HOLD: inst/inst_pc/valid stable, no imem_req.
//   Ready=1: next req 1 cycle later.
// - Halt: assert halt in WAIT for inst_pc=12.
//   Instruction 12 delivered, then IDLE, busy=0.
//   start=1 -> imem_addr=16.
// - Wrap/reset: pc=64'hFFFF_FFFF_FFFF_FFFC, no branch -> next imem_addr=0.
//   rst=0 in WAIT -> all outputs 0; later rvalid ignored; start -> imem_addr=RESET_PC.
// - FETCH_TIMEOUT_EN: rvalid never returned -> fetch_err=1 after 16 WAIT cycles, IDLE.
//   start ignored; reset clears fetch_err.

Source files
------------

// File: rtl/fetch_seq_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the imem handshake, feeds decode.
// Optional fetch timeout is enabled with `define FETCH_TIMEOUT_EN.
module fetch_seq_ctrl #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_offset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            busy,
  output logic            fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [31:0]     inst_q, inst_d;
  logic            halt_q, halt_d;
  logic            req_q, req_d;
  logic            vld_q, vld_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Next state, datapath updates and next registered outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    inst_d  = inst_q;
    halt_d  = halt_q;
    err_d   = err_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        halt_d = 1'b0;
        if (start && !halt && !err_q) state_d = S_REQ;
      end
      S_REQ: begin
        halt_d  = halt_q | halt;
        state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        halt_d = halt_q | halt;
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          ipc_d   = pc_q;
          state_d = S_HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          halt_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_HOLD: begin
        halt_d = halt_q | halt;
        if (inst_ready) begin
          pc_d    = ipc_q + (br_taken ? br_offset : XLEN'(4));
          state_d = (halt_q | halt) ? S_IDLE : S_REQ;
          halt_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_d  = (state_d == S_REQ);
    addr_d = req_d ? pc_d : '0;
    vld_d  = (state_d == S_HOLD);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ipc_q   <= '0;
      inst_q  <= '0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      inst_q  <= inst_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = vld_q;
  assign inst       = inst_q;
  assign inst_pc    = ipc_q;
  assign busy       = busy_q;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl.
// Timeout checks run only when FETCH_TIMEOUT_EN is defined.
module tb_fetch_seq_ctrl;

  localparam int XLEN = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            halt;
  logic            br_taken;
  logic [XLEN-1:0] br_offset;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            busy;
  logic            fetch_err;

  int n_chk = 0;
  int n_err = 0;
  bit mem_on = 1'b1;

  fetch_seq_ctrl #(
    .XLEN(XLEN),
    .RESET_PC('0),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .halt(halt),
    .br_taken(br_taken),
    .br_offset(br_offset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .busy(busy),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; a 1-cycle memory answers the request seen before the edge.
  task automatic tick();
    logic req_seen;
    req_seen = imem_req;
    @(posedge clk);
    #1;
    if (mem_on) begin
      imem_rvalid = req_seen;
      imem_rdata  = NOP;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"},  64'(imem_req),   64'd0);
    chk({tag, "_addr"}, imem_addr,       64'd0);
    chk({tag, "_vld"},  64'(inst_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy),       64'd0);
  endtask

  // Called in REQ; leaves the DUT in HOLD with the instruction checked.
  task automatic fetch_one(input string tag, input logic [63:0] pc);
    chk({tag, "_req"},  64'(imem_req),   64'd1);
    chk({tag, "_addr"}, imem_addr,       pc);
    chk({tag, "_vld0"}, 64'(inst_valid), 64'd0);
    tick();
    chk({tag, "_wait"}, 64'(imem_req),   64'd0);
    tick();
    chk({tag, "_vld"},  64'(inst_valid), 64'd1);
    chk({tag, "_inst"}, 64'(inst),       64'(NOP));
    chk({tag, "_ipc"},  inst_pc,         pc);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; halt = 1'b0; br_taken = 1'b0;
    br_offset = '0; imem_rvalid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b1;
    tick();
    tick();
    chk_idle("rst");
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_ipc",  inst_pc,   64'd0);
    chk("rst_err",  64'(fetch_err), 64'd0);

    rst = 1'b1;
    tick();
    chk_idle("idle_nostart");
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch_one("f0", 64'd0);
    tick();
    // br_taken outside the handshake must not redirect.
    br_taken = 1'b1; br_offset = 64'd100;
    chk("f4_busy", 64'(busy), 64'd1);
    chk("f4_req",  64'(imem_req), 64'd1);
    chk("f4_addr", imem_addr, 64'd4);
    tick();
    tick();
    chk("f4_ipc", inst_pc, 64'd4);
    br_taken = 1'b0;
    tick();
    fetch_one("f8", 64'd8);
    br_taken = 1'b1;
    br_offset = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    br_taken = 1'b0;
    br_offset = 64'd100;
    fetch_one("br0", 64'd0);

    // Backpressure in HOLD.
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_vld",  64'(inst_valid), 64'd1);
      chk("bp_ipc",  inst_pc,         64'd0);
      chk("bp_inst", 64'(inst),       64'(NOP));
      chk("bp_req",  64'(imem_req),   64'd0);
    end
    inst_ready = 1'b1;
    tick();
    fetch_one("bp4", 64'd4);
    tick();
    fetch_one("f8b", 64'd8);
    tick();

    // Halt raised for one cycle while waiting on instruction 12.
    chk("h12_req",  64'(imem_req), 64'd1);
    chk("h12_addr", imem_addr,     64'd12);
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("h12_vld", 64'(inst_valid), 64'd1);
    chk("h12_ipc", inst_pc,         64'd12);
    tick();
    chk_idle("halted");
    tick();
    chk_idle("halted2");
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch_one("res16", 64'd16);

    // Branch to the top of the address space, then wrap.
    br_taken = 1'b1;
    br_offset = 64'hFFFF_FFFF_FFFF_FFEC;
    tick();
    br_taken = 1'b0;
    fetch_one("top", 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_req",  64'(imem_req), 64'd1);
    chk("wrap_addr", imem_addr,     64'd0);

    // Reset while waiting; a late rvalid must be ignored.
    tick();
    mem_on = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst = 1'b0;
    tick();
    chk_idle("wrst");
    chk("wrst_ipc", inst_pc, 64'd0);
    rst = 1'b1;
    tick();
    tick();
    chk_idle("late_rv");
    chk("late_inst", 64'(inst), 64'd0);
    imem_rvalid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rpc_req",  64'(imem_req), 64'd1);
    chk("rpc_addr", imem_addr,     64'd0);

`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 16; i++) tick();
    chk("to_busy", 64'(busy),      64'd1);
    chk("to_err0", 64'(fetch_err), 64'd0);
    tick();
    chk("to_err",  64'(fetch_err), 64'd1);
    chk("to_idle", 64'(busy),      64'd0);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    chk("to_nost", 64'(busy),      64'd0);
    chk("to_sty",  64'(fetch_err), 64'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("to_clr",  64'(fetch_err), 64'd0);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("nto_busy", 64'(busy),       64'd1);
    chk("nto_err",  64'(fetch_err),  64'd0);
    chk("nto_vld",  64'(inst_valid), 64'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_rvalid = 1'b0;
    chk("nto_hold", 64'(inst_valid), 64'd1);
    chk("nto_inst", 64'(inst),       64'h0000_0000_CAFE_F00D);
    chk("nto_ipc",  inst_pc,         64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
